// File: rtl/nios2_sysid_pkg.sv
// Shared definitions for the Nios II system-ID checker: FSM encoding,
// default expected ID/timestamp words and the timeout counter width.
package nios2_sysid_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_ID,
    S_WT_ID,
    S_RD_TS,
    S_WT_TS,
    S_FIN
  } state_t;

  localparam logic [31:0] DEF_EXP_ID = 32'h0000A010;
  localparam logic [31:0] DEF_EXP_TS = 32'h52A1B2E7;
  localparam int unsigned CTR_W      = 16;

endpackage

// File: rtl/sysid_timeout_ctr.sv
// Per-state cycle counter for the sysid checker; expired flags the cycle in
// which the current state has been occupied for 'limit' cycles.
module sysid_timeout_ctr
  import nios2_sysid_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic [CTR_W-1:0] limit,
  output logic             expired
);

  logic [CTR_W-1:0] count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)       count <= '0;
    else if (clear)  count <= '0;
    else if (enable) count <= count + 1'b1;
  end

  // count holds cycles already spent in the state, so +1 includes the current one
  always_comb expired = enable && (({1'b0, count} + 1'b1) >= {1'b0, limit});

endmodule

// File: rtl/nios2_sysid_checker.sv
// Reads the sysid ID and timestamp words over Avalon-MM and compares them.
// Define SYSID_CHECK_TIMEOUT_EN to abort stalled reads after TIMEOUT_CYCLES.
module nios2_sysid_checker
  import nios2_sysid_pkg::*;
#(
  parameter logic [31:0] EXP_ID         = DEF_EXP_ID,
  parameter logic [31:0] EXP_TS         = DEF_EXP_TS,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd1024
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  input  logic        avm_readdatavalid,
  output logic        busy,
  output logic        done,
  output logic [31:0] id_word,
  output logic [31:0] ts_word,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout_err
);

  state_t state, state_nx;
  logic   accept;
  logic   tmo;
  logic   cap_id;
  logic   cap_ts;

`ifdef SYSID_CHECK_TIMEOUT_EN
  logic ctr_en;

  always_comb ctr_en = (state == S_RD_ID) || (state == S_WT_ID) ||
                       (state == S_RD_TS) || (state == S_WT_TS);

  sysid_timeout_ctr u_timeout_ctr (
    .clock   (clock),
    .reset   (reset),
    .clear   (state_nx != state),
    .enable  (ctr_en),
    .limit   (TIMEOUT_CYCLES),
    .expired (tmo)
  );
`else
  always_comb tmo = 1'b0;
`endif

  always_comb begin
    avm_read    = (state == S_RD_ID) || (state == S_RD_TS);
    avm_address = (state == S_RD_TS) || (state == S_WT_TS);
    busy        = (state != S_IDLE);
    done        = (state == S_FIN);
    accept      = avm_read && !avm_waitrequest;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  // a zero-latency slave returns data in the accept cycle, so skip WT_*
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (start) state_nx = S_RD_ID;
      S_RD_ID: if (tmo) state_nx = S_FIN;
               else if (accept) state_nx = avm_readdatavalid ? S_RD_TS : S_WT_ID;
      S_WT_ID: if (tmo) state_nx = S_FIN;
               else if (avm_readdatavalid) state_nx = S_RD_TS;
      S_RD_TS: if (tmo) state_nx = S_FIN;
               else if (accept) state_nx = avm_readdatavalid ? S_FIN : S_WT_TS;
      S_WT_TS: if (tmo || avm_readdatavalid) state_nx = S_FIN;
      S_FIN:   state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    cap_id = !tmo && avm_readdatavalid &&
             ((state == S_WT_ID) || ((state == S_RD_ID) && accept));
    cap_ts = !tmo && avm_readdatavalid &&
             ((state == S_WT_TS) || ((state == S_RD_TS) && accept));
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      id_word     <= '0;
      ts_word     <= '0;
      id_ok       <= 1'b0;
      ts_ok       <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      if ((state == S_IDLE) && start) begin
        id_ok       <= 1'b0;
        ts_ok       <= 1'b0;
        timeout_err <= 1'b0;
      end
      if (cap_id) begin
        id_word <= avm_readdata;
        id_ok   <= (avm_readdata == EXP_ID);
      end
      if (cap_ts) begin
        ts_word <= avm_readdata;
        ts_ok   <= (avm_readdata == EXP_TS);
      end
      if (tmo) begin
        id_ok       <= 1'b0;
        ts_ok       <= 1'b0;
        timeout_err <= 1'b1;
      end
    end
  end

endmodule

// File: doc/nios2_sysid_checker.md
NIOS2_SYSID_CHECKER -- requirements
Module: nios2_sysid_checker

Interface
REQ-001 Parameter EXP_ID, default 32'h0000A010, expected system ID word (word 0).
REQ-002 Parameter EXP_TS, default 32'h52A1B2E7, expected build timestamp word (word 1).
REQ-003 Parameter TIMEOUT_CYCLES, default 16'd1024, maximum cycles per read transaction before abort.
REQ-004 Port clock, input, 1, single clock for all logic.
REQ-005 Port reset, input, 1, asynchronous active-high reset.
REQ-006 Port start, input, 1, one-cycle pulse requesting a check sequence.
REQ-007 Port avm_address, output, 1, word select (0 = ID, 1 = timestamp).
REQ-008 Port avm_read, output, 1, Avalon-MM read request.
REQ-009 Port avm_waitrequest, input, 1, slave stall; request held while high.
REQ-010 Port avm_readdata, input, 32, read data.
REQ-011 Port avm_readdatavalid, input, 1, qualifies avm_readdata.
REQ-012 Port busy, output, 1, high while a sequence is running.
REQ-013 Port done, output, 1, one-cycle pulse at sequence end.
REQ-014 Port id_word / ts_word, output, 32 each, captured words.
REQ-015 Port id_ok / ts_ok, output, 1 each, compare results, valid from done onward.
REQ-016 Port timeout_err, output, 1, sticky abort flag for the last sequence.

Function
REQ-017 FSM states IDLE, RD_ID, WT_ID, RD_TS, WT_TS, FIN; one-hot or binary at implementer's choice.
REQ-018 IDLE + start -> RD_ID next cycle; busy rises the same edge; id_ok, ts_ok, timeout_err clear on that edge.
REQ-019 start while busy is ignored; no queuing.
REQ-020 RD_ID: avm_read=1, avm_address=0; held stable while avm_waitrequest=1; on read & !waitrequest -> WT_ID.
REQ-021 WT_ID: avm_read=0; on avm_readdatavalid capture id_word, id_ok <= (readdata == EXP_ID), -> RD_TS.
REQ-022 readdatavalid in the acceptance cycle of RD_ID (zero-latency slave) is captured directly, skipping WT_ID.
REQ-023 RD_TS/WT_TS identical to RD_ID/WT_ID with avm_address=1, EXP_TS, ts_word, ts_ok; next state FIN.
REQ-024 FIN: done=1 for exactly one cycle, busy=0 from the following cycle, -> IDLE.
REQ-025 readdatavalid outside WT_*/accepting RD_* is ignored.
REQ-026 Minimum sequence with zero-wait, one-cycle-latency slave: start to done = 6 cycles.

Reset
REQ-027 reset forces IDLE asynchronously; avm_read, busy, done, id_ok, ts_ok, timeout_err = 0; id_word, ts_word = 0.
REQ-028 Reset mid-transaction abandons it; no done pulse is issued.

Configuration
REQ-029 With SYSID_CHECK_TIMEOUT_EN defined: a 16-bit counter clears on every state entry, increments in RD_*/WT_*; reaching TIMEOUT_CYCLES -> FIN with avm_read=0, timeout_err=1, both ok flags 0.
REQ-030 Without SYSID_CHECK_TIMEOUT_EN: no counter, FSM waits indefinitely, timeout_err tied 0, TIMEOUT_CYCLES unused.

Structure
REQ-031 Shared package nios2_sysid_pkg holds state encoding, default EXP_ID/EXP_TS constants, counter width.
REQ-032 Timeout counter is sub-module sysid_timeout_ctr (clear, enable, limit, expired), instantiated only under the macro.

Verification
REQ-033 Zero-wait slave returning 0x0000A010 then 0x52A1B2E7 -> done at cycle 6, id_ok=1, ts_ok=1, timeout_err=0.
REQ-034 Word 0 returns 0x0000A011 -> id_ok=0, ts_ok=1, id_word=0x0000A011.
REQ-035 waitrequest high 5 cycles on word 1 -> avm_read/address stable throughout, done at cycle 11, both ok.
REQ-036 Macro on, TIMEOUT_CYCLES=16, readdatavalid never asserted -> done 17 cycles after RD_ID entry, timeout_err=1, avm_read=0.
REQ-037 reset asserted in WT_TS -> immediate IDLE, all outputs 0, no done; subsequent start completes normally.
REQ-038 start pulsed again while busy -> exactly one done pulse per accepted start.
